// File: rtl/counter_pkg.sv
// Shared types for the generic up/down event/timer counter.
// Boundary modes, the one-shot run/halt state and the per-cycle event record.
package counter_pkg;

  // Boundary behaviour selected by the 2-bit mode input
  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    MOD     = 2'd2,
    ONESHOT = 2'd3
  } mode_e;

  // ONESHOT parks in HALT after its first boundary event
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // Boundary event produced by one count step
  typedef struct packed {
    logic ovf;
    logic unf;
  } event_t;

  // SAT and ONESHOT clamp at the boundary. WRAP and MOD fold around it.
  function automatic logic mode_clamps(input mode_e m);
    return (m == SAT) || (m == ONESHOT);
  endfunction

endpackage

// File: rtl/counter_step_alu.sv
// Combinational step unit: takes the current count, the effective step, the
// active top value, the direction and the mode. Returns the next count and
// any boundary event. All comparisons run one bit wider than the count, so
// the carry out of cur+s and the span top+1 are never lost.
module counter_step_alu
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] s,
  input  logic [WIDTH-1:0]  top,
  input  logic              updn,
  input  mode_e             mode,
  output logic [WIDTH-1:0]  nxt,
  output event_t            evt
);

  localparam int EW = WIDTH + 1;

  logic [EW-1:0] cur_x;
  logic [EW-1:0] s_x;
  logic [EW-1:0] top_x;
  logic [EW-1:0] span_x;
  logic [EW-1:0] sum_x;
  logic [EW-1:0] wrap_up_x;
  logic [EW-1:0] wrap_dn_x;
  logic          clamp;

  assign cur_x     = {1'b0, cur};
  assign s_x       = EW'(s);
  assign top_x     = {1'b0, top};
  assign span_x    = top_x + EW'(1);
  assign sum_x     = cur_x + s_x;
  assign wrap_up_x = sum_x - span_x;
  assign wrap_dn_x = cur_x + span_x - s_x;
  assign clamp     = mode_clamps(mode);

  // Next value and event. A zero step is a pure hold and never raises an event.
  always_comb begin
    nxt = cur;
    evt = '0;
    if (s != '0) begin
      if (updn) begin
        if ((mode == MOD) && (cur > top)) begin
          // The limit was lowered below the count. Any up step is an overflow back to 0.
          evt.ovf = 1'b1;
          nxt     = '0;
        end else if (sum_x > top_x) begin
          evt.ovf = 1'b1;
          nxt     = clamp ? top : wrap_up_x[WIDTH-1:0];
        end else begin
          nxt = sum_x[WIDTH-1:0];
        end
      end else begin
        if (cur_x < s_x) begin
          evt.unf = 1'b1;
          nxt     = clamp ? '0 : wrap_dn_x[WIDTH-1:0];
        end else begin
          nxt = cur - WIDTH'(s);
        end
      end
    end
  end

endmodule

// File: rtl/updn_counter_gen2.sv
// Parametrised loadable up/down counter with selectable boundary modes.
// Modes are wrap, saturate, modulo-limit and one-shot. It has a registered
// terminal-count pulse and sticky overflow/underflow flags. Priority each
// cycle: reset, then load, then count, then hold.
module updn_counter_gen2
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_cnt_,
  input  logic              count_enb,
  input  logic              updn_cnt,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  cnt_limit,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic              ovf_flag,
  output logic              unf_flag,
  output logic              halted
);

  mode_e             mode_q;
  logic [WIDTH-1:0]  top;
  logic [STEP_W-1:0] step_eff;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  alu_nxt;
  event_t            alu_evt;
  logic              count_fire;
  logic              any_evt;

  state_e            state_reg;
  logic [WIDTH-1:0]  data_out_reg;
  logic              tc_reg;
  logic              ovf_flag_reg;
  logic              unf_flag_reg;
  logic              halted_reg;

  assign mode_q = mode_e'(mode);

  // In MOD mode the top value is the runtime limit. In every other mode it is all ones.
  assign top = (mode_q == MOD) ? cnt_limit : '1;

  // In MOD mode the step never exceeds the limit. If the limit is below the
  // step, it also fits in STEP_W bits, so the truncation is lossless.
  assign step_eff = ((mode_q == MOD) && (WIDTH'(step) > cnt_limit))
                    ? cnt_limit[STEP_W-1:0] : step;

  // In MOD mode, a load value above the limit is clamped to the limit.
  assign load_val = ((mode_q == MOD) && (data_in > cnt_limit)) ? cnt_limit : data_in;

  counter_step_alu #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_alu (
    .cur  (data_out_reg),
    .s    (step_eff),
    .top  (top),
    .updn (updn_cnt),
    .mode (mode_q),
    .nxt  (alu_nxt),
    .evt  (alu_evt)
  );

  // A count step is taken only when no load is pending and the FSM is running.
  assign count_fire = ld_cnt_ && count_enb && (state_reg == RUN);
  assign any_evt    = alu_evt.ovf || alu_evt.unf;

  // Count register, run/halt FSM, tc pulse and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      data_out_reg <= '0;
      tc_reg       <= 1'b0;
      ovf_flag_reg <= 1'b0;
      unf_flag_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      tc_reg <= 1'b0;
      if (!ld_cnt_) begin
        data_out_reg <= load_val;
        state_reg    <= RUN;
        halted_reg   <= 1'b0;
      end else if (count_fire) begin
        data_out_reg <= alu_nxt;
        tc_reg       <= any_evt;
        if ((mode_q == ONESHOT) && any_evt) begin
          state_reg  <= HALT;
          halted_reg <= 1'b1;
        end
      end
      // A new event wins over a clear requested in the same cycle.
      ovf_flag_reg <= (count_fire && alu_evt.ovf) || (ovf_flag_reg && !clr_flags);
      unf_flag_reg <= (count_fire && alu_evt.unf) || (unf_flag_reg && !clr_flags);
    end
  end

  assign data_out = data_out_reg;
  assign tc       = tc_reg;
  assign ovf_flag = ovf_flag_reg;
  assign unf_flag = unf_flag_reg;
  assign halted   = halted_reg;

endmodule

// File: tb/tb_updn_counter_gen2.sv
// Directed vector bench for updn_counter_gen2 (WIDTH=8, STEP_W=4).
// The table holds one clock per row, with its inputs and the outputs expected
// after that edge. A hand-written sequence follows: a long WRAP run whose
// expected values come from a small reference model.
module tb_updn_counter_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_cnt_;
  logic       count_enb;
  logic       updn_cnt;
  logic [1:0] mode;
  logic [3:0] step;
  logic [7:0] cnt_limit;
  logic [7:0] data_in;
  logic       clr_flags;
  logic [7:0] data_out;
  logic       tc;
  logic       ovf_flag;
  logic       unf_flag;
  logic       halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updn_counter_gen2 #(.WIDTH(8), .STEP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_cnt_   (ld_cnt_),
    .count_enb (count_enb),
    .updn_cnt  (updn_cnt),
    .mode      (mode),
    .step      (step),
    .cnt_limit (cnt_limit),
    .data_in   (data_in),
    .clr_flags (clr_flags),
    .data_out  (data_out),
    .tc        (tc),
    .ovf_flag  (ovf_flag),
    .unf_flag  (unf_flag),
    .halted    (halted)
  );

  typedef struct packed {
    logic       rst;
    logic       ld_n;
    logic       en;
    logic       up;
    logic [1:0] mode;
    logic [3:0] step;
    logic [7:0] lim;
    logic [7:0] din;
    logic       clr;
    logic [7:0] e_dout;
    logic       e_tc;
    logic       e_ovf;
    logic       e_unf;
    logic       e_halt;
  } vec_t;

  localparam int NV = 41;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic ldn, input logic en, input logic up,
                              input logic [1:0] md, input logic [3:0] st, input logic [7:0] lim,
                              input logic [7:0] din, input logic clr, input logic [7:0] dout,
                              input logic etc, input logic eo, input logic eu, input logic eh);
    vec_t v;
    v.rst = r;  v.ld_n = ldn; v.en = en; v.up = up; v.mode = md; v.step = st;
    v.lim = lim; v.din = din; v.clr = clr;
    v.e_dout = dout; v.e_tc = etc; v.e_ovf = eo; v.e_unf = eu; v.e_halt = eh;
    return v;
  endfunction

  task automatic drive(input logic r, input logic ldn, input logic en, input logic up,
                       input logic [1:0] md, input logic [3:0] st, input logic [7:0] lim,
                       input logic [7:0] din, input logic clr);
    rst = r; ld_cnt_ = ldn; count_enb = en; updn_cnt = up; mode = md;
    step = st; cnt_limit = lim; data_in = din; clr_flags = clr;
  endtask

  task automatic check(input string name, input logic [7:0] dout, input logic etc,
                       input logic eo, input logic eu, input logic eh);
    checks++;
    if (data_out !== dout || tc !== etc || ovf_flag !== eo || unf_flag !== eu || halted !== eh) begin
      errors++;
      $display("FAIL %s: got dout=%02h tc=%0b ovf=%0b unf=%0b halt=%0b, want dout=%02h tc=%0b ovf=%0b unf=%0b halt=%0b",
               name, data_out, tc, ovf_flag, unf_flag, halted, dout, etc, eo, eu, eh);
    end else begin
      $display("ok   %s: dout=%02h tc=%0b ovf=%0b unf=%0b halt=%0b",
               name, data_out, tc, ovf_flag, unf_flag, halted);
    end
  endtask

  initial begin
    //              rst ld en up mode  st    lim    din    clr  dout  tc o  u  h
    vecs[0]  = mk(1, 1, 0, 0, 2'd0, 4'd0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0); // reset
    vecs[1]  = mk(0, 0, 0, 0, 2'd0, 4'd0, 8'h00, 8'h5A, 0, 8'h5A, 0, 0, 0, 0); // load 5A
    vecs[2]  = mk(1, 0, 0, 0, 2'd0, 4'd0, 8'h00, 8'h77, 0, 8'h00, 0, 0, 0, 0); // rst beats load
    vecs[3]  = mk(0, 0, 0, 0, 2'd0, 4'd0, 8'h00, 8'hFE, 0, 8'hFE, 0, 0, 0, 0); // WRAP load FE
    vecs[4]  = mk(0, 1, 1, 1, 2'd0, 4'd3, 8'h00, 8'h00, 0, 8'h01, 1, 1, 0, 0); // wrap up
    vecs[5]  = mk(0, 1, 1, 1, 2'd0, 4'd3, 8'h00, 8'h00, 0, 8'h04, 0, 1, 0, 0); // tc one cycle
    vecs[6]  = mk(0, 1, 0, 1, 2'd0, 4'd3, 8'h00, 8'h00, 0, 8'h04, 0, 1, 0, 0); // hold, flag sticky
    vecs[7]  = mk(0, 1, 0, 1, 2'd0, 4'd3, 8'h00, 8'h00, 1, 8'h04, 0, 0, 0, 0); // clear flags
    vecs[8]  = mk(0, 0, 0, 0, 2'd1, 4'd0, 8'h00, 8'h02, 0, 8'h02, 0, 0, 0, 0); // SAT load 02
    vecs[9]  = mk(0, 1, 1, 0, 2'd1, 4'd5, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0); // sat underflow
    vecs[10] = mk(0, 1, 1, 0, 2'd1, 4'd5, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0); // again, tc again
    vecs[11] = mk(0, 1, 1, 0, 2'd1, 4'd5, 8'h00, 8'h00, 1, 8'h00, 1, 0, 1, 0); // set beats clear
    vecs[12] = mk(0, 1, 0, 0, 2'd1, 4'd5, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0); // clear
    vecs[13] = mk(0, 0, 0, 1, 2'd2, 4'd2, 8'd9,  8'd7,  0, 8'd7,  0, 0, 0, 0); // modulo-limit load 7
    vecs[14] = mk(0, 1, 1, 1, 2'd2, 4'd2, 8'd9,  8'd0,  0, 8'd9,  0, 0, 0, 0); // 7+2=9
    vecs[15] = mk(0, 1, 1, 1, 2'd2, 4'd2, 8'd9,  8'd0,  0, 8'd1,  1, 1, 0, 0); // 11-10=1
    vecs[16] = mk(0, 1, 1, 1, 2'd2, 4'd2, 8'd9,  8'd0,  0, 8'd3,  0, 1, 0, 0); // 3
    vecs[17] = mk(0, 0, 0, 1, 2'd2, 4'd2, 8'd9,  8'd20, 0, 8'd9,  0, 1, 0, 0); // load clamp
    vecs[18] = mk(0, 0, 1, 1, 2'd2, 4'd2, 8'd9,  8'd5,  1, 8'd5,  0, 0, 0, 0); // load beats count
    vecs[19] = mk(0, 1, 1, 1, 2'd2, 4'd2, 8'd3,  8'd0,  0, 8'd0,  1, 1, 0, 0); // above limit, up
    vecs[20] = mk(0, 1, 1, 0, 2'd2, 4'd2, 8'd3,  8'd0,  0, 8'd2,  1, 1, 1, 0); // 0+4-2
    vecs[21] = mk(0, 0, 0, 1, 2'd2, 4'd0, 8'd0,  8'h33, 0, 8'd0,  0, 1, 1, 0); // limit 0 clamp
    vecs[22] = mk(0, 1, 1, 1, 2'd2, 4'd5, 8'd0,  8'h00, 0, 8'd0,  0, 1, 1, 0); // limit 0 hold
    vecs[23] = mk(0, 1, 1, 1, 2'd0, 4'd0, 8'd0,  8'h00, 0, 8'd0,  0, 1, 1, 0); // step 0 hold
    vecs[24] = mk(0, 0, 0, 0, 2'd3, 4'd1, 8'd0,  8'h03, 1, 8'h03, 0, 0, 0, 0); // ONESHOT load 3
    vecs[25] = mk(0, 1, 1, 0, 2'd3, 4'd1, 8'd0,  8'h00, 0, 8'h02, 0, 0, 0, 0);
    vecs[26] = mk(0, 1, 1, 0, 2'd3, 4'd1, 8'd0,  8'h00, 0, 8'h01, 0, 0, 0, 0);
    vecs[27] = mk(0, 1, 1, 0, 2'd3, 4'd1, 8'd0,  8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[28] = mk(0, 1, 1, 0, 2'd3, 4'd1, 8'd0,  8'h00, 0, 8'h00, 1, 0, 1, 1); // halt
    vecs[29] = mk(0, 1, 1, 0, 2'd3, 4'd1, 8'd0,  8'h00, 0, 8'h00, 0, 0, 1, 1); // halted hold
    vecs[30] = mk(0, 1, 1, 1, 2'd0, 4'd1, 8'd0,  8'h00, 0, 8'h00, 0, 0, 1, 1); // mode chg stays halted
    vecs[31] = mk(0, 0, 0, 1, 2'd3, 4'd1, 8'd0,  8'h10, 0, 8'h10, 0, 0, 1, 0); // load exits halt
    vecs[32] = mk(0, 1, 1, 1, 2'd3, 4'd1, 8'd0,  8'h00, 0, 8'h11, 0, 0, 1, 0); // resumes
    vecs[33] = mk(0, 0, 0, 1, 2'd0, 4'd1, 8'd0,  8'hFF, 0, 8'hFF, 0, 0, 1, 0); // WRAP load FF
    vecs[34] = mk(0, 1, 1, 1, 2'd0, 4'd1, 8'd0,  8'h00, 1, 8'h00, 1, 1, 0, 0); // ovf with clr
    vecs[35] = mk(0, 0, 0, 1, 2'd3, 4'd5, 8'd0,  8'hFE, 0, 8'hFE, 0, 1, 0, 0); // ONESHOT load FE
    vecs[36] = mk(0, 1, 1, 1, 2'd3, 4'd5, 8'd0,  8'h00, 0, 8'hFF, 1, 1, 0, 1); // clamp + halt
    vecs[37] = mk(1, 1, 1, 1, 2'd3, 4'd5, 8'd0,  8'h00, 0, 8'h00, 0, 0, 0, 0); // rst clears halt
    vecs[38] = mk(0, 0, 0, 1, 2'd1, 4'd5, 8'd0,  8'hFD, 0, 8'hFD, 0, 0, 0, 0); // SAT load FD
    vecs[39] = mk(0, 1, 1, 1, 2'd1, 4'd5, 8'd0,  8'h00, 0, 8'hFF, 1, 1, 0, 0); // sat up
    vecs[40] = mk(0, 1, 1, 1, 2'd1, 4'd5, 8'd0,  8'h00, 0, 8'hFF, 1, 1, 0, 0); // stays top

    drive(1, 1, 0, 0, 2'd0, 4'd0, 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].ld_n, vecs[i].en, vecs[i].up, vecs[i].mode,
            vecs[i].step, vecs[i].lim, vecs[i].din, vecs[i].clr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_tc, vecs[i].e_ovf,
            vecs[i].e_unf, vecs[i].e_halt);
    end

    // WRAP up by 7 from zero. tc must pulse only on the edge that carries past FF.
    drive(1, 1, 0, 0, 2'd0, 4'd0, 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;
    check("wrap7_rst", 8'h00, 0, 0, 0, 0);
    begin
      int   acc;
      int   sum;
      logic ovf_m;
      acc   = 0;
      ovf_m = 1'b0;
      for (int k = 0; k < 40; k++) begin
        drive(0, 1, 1, 1, 2'd0, 4'd7, 8'h00, 8'h00, 0);
        @(posedge clk);
        #1;
        sum   = acc + 7;
        ovf_m = ovf_m | (sum > 255);
        acc   = sum % 256;
        check($sformatf("wrap7_%0d", k), acc[7:0], (sum > 255), ovf_m, 1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
